piso_queue: RTL and testbench
=============================

Name: piso_queue

Overview:
- Parametrised parallel-in/serial-out converter with a one-entry pending buffer, variable load length and selectable element order.
- Accepts a DEPTH-element parallel word and emits it one element per read. A second word can be queued while the first drains, so output can run back-to-back with no bubble.
- Sits between wide memory/tile fetch logic and narrow per-pixel/per-byte consumers in the cave video and sound paths.

Parameters:
- DATA_WIDTH, 8: bits per element.
- DEPTH, 16: maximum elements per parallel word; must be >= 2.
- REVERSE, 0: 0 emits element 0 first; 1 emits element len-1 first, then down to 0.
- LEN_WIDTH, $clog2(DEPTH+1): width of the length and count fields.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_wr  in  1  write request; the word is accepted when io_wr && io_wr_ready.
- io_wr_ready  out  1  high when the pending buffer is free.
- io_len  in  LEN_WIDTH  number of valid elements in io_din. 0 means the write is accepted and discarded. Values above DEPTH are clamped to DEPTH.
- io_din  in  DATA_WIDTH*DEPTH  element i is io_din[i*DATA_WIDTH +: DATA_WIDTH].
- io_rd  in  1  pop request; ignored while io_isEmpty.
- io_dout  out  DATA_WIDTH  current head element, taken directly from the active slot 0 register.
- io_isEmpty  out  1  active count == 0.
- io_isAlmostEmpty  out  1  active count == 1.
- io_count  out  LEN_WIDTH  elements remaining in the active buffer.
- io_pending  out  1  pending buffer holds a word.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: while reset_n is low, all of the following hold:
  - active slots = 0, count = 0, pending valid = 0, pending slots/len = 0;
  - io_dout = 0, io_isEmpty = 1, io_isAlmostEmpty = 0, io_count = 0, io_wr_ready = 1, io_pending = 0.
  - Reset mid-drain discards both the active and pending words immediately.
- Storage:
  - Active buffer: DEPTH slots plus count.
  - Pending buffer: DEPTH slots, len, valid flag.
  - io_wr_ready = ~pending valid (combinational from a register).
- Load formatting (applied identically when loading active or pending), with L = clamped len:
  - REVERSE=0: slot j = din element j for j < L.
  - REVERSE=1: slot j = din element L-1-j.
  - Slots j >= L = 0.
- Pop (io_rd && count != 0):
  - slot j <= slot j+1; top slot <= 0; count <= count-1.
  - io_dout reflects the new head the following cycle (zero read latency for the current head).
- Accepted write with L != 0, evaluated after the same-cycle pop:
  - Active effectively empty (count == 0, or count == 1 with a pop this cycle): load active, count <= L.
  - Otherwise: load pending, pending valid <= 1.
- Pending promotion: on the pop that takes count from 1 to 0 with pending valid set:
  - load active from pending in the same edge; count <= pending len; pending valid <= 0.
  - io_wr_ready returns high the next cycle; there is no empty cycle between words.
- Simultaneous pop of the last element + write + no pending: the write goes to active (no bubble).
- Write while io_wr_ready = 0: ignored. Neither buffer is modified; the write never overwrites queued data.
- Write with L = 0: accepted (handshake completes) but has no effect on any state.
- Pop while empty: no effect; io_dout stays 0 after the final element has shifted out.
- Count arithmetic: unsigned LEN_WIDTH; never wraps below 0 or exceeds DEPTH.
- Flags and io_count are driven purely from registers; no combinational input-to-flag paths.

Test Plan:
- Reset/basic drain (DEPTH=16, REVERSE=0): assert reset_n=0 mid-operation -> all outputs at reset values immediately. Then write din elements = 0x10..0x1F, len=16, and pop 16 cycles -> io_dout reads 0x10..0x1F in order, io_isAlmostEmpty high before the last pop, then io_isEmpty=1 and io_dout=0.
- Reverse + short length (REVERSE=1): write elements 0xA0..0xAF with len=4 -> io_count=4; pops yield 0xA3, 0xA2, 0xA1, 0xA0; then empty, io_dout=0.
- Back-to-back queueing: write word A (len 3, elements 1,2,3); write word B (len 2, elements 7,8) while A drains -> io_pending=1 and io_wr_ready=0. Continuous pops yield 1,2,3,7,8 with io_isEmpty never high in between; io_wr_ready rises the cycle after 3 is popped.
- Blocked write: with pending full, drive a third write (elements 0xEE) -> ignored; the output sequence is unchanged and 0xEE never appears.
- Boundary lengths: len=0 write -> io_count stays 0 and io_isEmpty stays 1. len=20 (DEPTH=16) -> io_count=16.
- Coincident last pop + write (no pending): count=1 holding 0x55, io_rd=1 and io_wr=1 with elements 0x66,0x67 (len 2) -> next cycle io_dout=0x66 and io_count=2, with no empty cycle.

Source files
------------

// File: rtl/piso_queue.sv
`default_nettype none
// ============================================================================
// Module      : piso_queue
// Description : Parallel-in / serial-out converter with a one-entry pending
//               buffer. A DEPTH-element word is loaded into the active buffer
//               and shifted out one element per pop; a second word may be
//               parked in the pending buffer and is promoted on the pop of
//               the last active element, so output runs without a bubble.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   sole clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   io_wr            in   write request (accepted when io_wr && io_wr_ready)
//   io_wr_ready      out  pending buffer is free
//   io_len           in   valid elements in io_din (0 = discard, >DEPTH clamped)
//   io_din           in   element i at io_din[i*DATA_WIDTH +: DATA_WIDTH]
//   io_rd            in   pop request (ignored while empty)
//   io_dout          out  current head element (active slot 0)
//   io_isEmpty       out  active count == 0
//   io_isAlmostEmpty out  active count == 1
//   io_count         out  elements remaining in the active buffer
//   io_pending       out  pending buffer holds a word
// ============================================================================
module piso_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int REVERSE    = 0,
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        io_wr,
    output logic                        io_wr_ready,
    input  logic [LEN_WIDTH-1:0]        io_len,
    input  logic [DATA_WIDTH*DEPTH-1:0] io_din,
    input  logic                        io_rd,
    output logic [DATA_WIDTH-1:0]       io_dout,
    output logic                        io_isEmpty,
    output logic                        io_isAlmostEmpty,
    output logic [LEN_WIDTH-1:0]        io_count,
    output logic                        io_pending
);

    localparam logic [LEN_WIDTH-1:0] C_DEPTH = LEN_WIDTH'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] C_ONE   = LEN_WIDTH'(1);

    // Active buffer
    logic [DATA_WIDTH-1:0] slots_q [DEPTH];
    logic [DATA_WIDTH-1:0] slots_d [DEPTH];
    logic [LEN_WIDTH-1:0]  count_q;
    logic [LEN_WIDTH-1:0]  count_d;

    // Pending buffer
    logic [DATA_WIDTH-1:0] pend_slots_q [DEPTH];
    logic [DATA_WIDTH-1:0] pend_slots_d [DEPTH];
    logic [LEN_WIDTH-1:0]  pend_len_q;
    logic [LEN_WIDTH-1:0]  pend_len_d;
    logic                  pend_valid_q;
    logic                  pend_valid_d;

    // Formatted incoming word
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic [DATA_WIDTH-1:0] fmt_slots [DEPTH];

    logic                  pop;
    logic                  last_pop;
    logic                  wr_load;

    // ------------------------------------------------------------------------
    // Load formatting: clamp the length, place the valid elements in emission
    // order starting at slot 0 and zero everything above the length.
    // ------------------------------------------------------------------------
    always_comb begin
        len_clamped = (io_len > C_DEPTH) ? C_DEPTH : io_len;
        for (int j = 0; j < DEPTH; j++) begin
            fmt_slots[j] = '0;
            if (LEN_WIDTH'(j) < len_clamped) begin
                if (REVERSE != 0) begin
                    // Slot j takes element len-1-j; j < len so no underflow.
                    for (int k = 0; k < DEPTH; k++) begin
                        if (LEN_WIDTH'(k) == (len_clamped - C_ONE - LEN_WIDTH'(j))) begin
                            fmt_slots[j] = io_din[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end else begin
                    fmt_slots[j] = io_din[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign pop      = io_rd && (count_q != '0);
    assign last_pop = pop && (count_q == C_ONE);
    // A write is only honoured while the pending buffer is free; a zero
    // length completes the handshake but changes nothing.
    assign wr_load  = io_wr && !pend_valid_q && (len_clamped != '0);

    // ------------------------------------------------------------------------
    // Next-state logic. Pop first, then promotion, then the write, which sees
    // the active buffer as empty if its last element leaves this cycle.
    // Promotion and a write never coincide: a write needs pending free.
    // ------------------------------------------------------------------------
    always_comb begin
        slots_d      = slots_q;
        count_d      = count_q;
        pend_slots_d = pend_slots_q;
        pend_len_d   = pend_len_q;
        pend_valid_d = pend_valid_q;

        if (pop) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                slots_d[j] = slots_q[j+1];
            end
            slots_d[DEPTH-1] = '0;
            count_d          = count_q - C_ONE;
        end

        if (last_pop && pend_valid_q) begin
            slots_d      = pend_slots_q;
            count_d      = pend_len_q;
            pend_valid_d = 1'b0;
            pend_len_d   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                pend_slots_d[j] = '0;
            end
        end

        if (wr_load) begin
            if ((count_q == '0) || last_pop) begin
                slots_d = fmt_slots;
                count_d = len_clamped;
            end else begin
                pend_slots_d = fmt_slots;
                pend_len_d   = len_clamped;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                slots_q[j]      <= '0;
                pend_slots_q[j] <= '0;
            end
            count_q      <= '0;
            pend_len_q   <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            slots_q      <= slots_d;
            count_q      <= count_d;
            pend_slots_q <= pend_slots_d;
            pend_len_q   <= pend_len_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // All outputs decode registered state only.
    assign io_dout          = slots_q[0];
    assign io_count         = count_q;
    assign io_isEmpty       = (count_q == '0);
    assign io_isAlmostEmpty = (count_q == C_ONE);
    assign io_pending       = pend_valid_q;
    assign io_wr_ready      = !pend_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_queue
// Description : Self-checking bench for piso_queue. One instance in forward
//               order and one in reverse order; expected elements are queued
//               when a write is driven and compared as elements are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_queue;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int LW = $clog2(DP + 1);

    logic            clock;
    logic            reset_n;

    // Forward-order instance
    logic            wr;
    logic            wr_ready;
    logic [LW-1:0]   len;
    logic [DW*DP-1:0] din;
    logic            rd;
    logic [DW-1:0]   dout;
    logic            empty;
    logic            almost;
    logic [LW-1:0]   count;
    logic            pending;

    // Reverse-order instance
    logic            rv_wr;
    logic            rv_wr_ready;
    logic [LW-1:0]   rv_len;
    logic [DW*DP-1:0] rv_din;
    logic            rv_rd;
    logic [DW-1:0]   rv_dout;
    logic            rv_empty;
    logic            rv_almost;
    logic [LW-1:0]   rv_count;
    logic            rv_pending;

    logic [DW-1:0]   q  [$];
    logic [DW-1:0]   qr [$];
    int              n_checks = 0;
    int              n_errors = 0;

    piso_queue #(.DATA_WIDTH(DW), .DEPTH(DP), .REVERSE(0)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .io_wr            (wr),
        .io_wr_ready      (wr_ready),
        .io_len           (len),
        .io_din           (din),
        .io_rd            (rd),
        .io_dout          (dout),
        .io_isEmpty       (empty),
        .io_isAlmostEmpty (almost),
        .io_count         (count),
        .io_pending       (pending)
    );

    piso_queue #(.DATA_WIDTH(DW), .DEPTH(DP), .REVERSE(1)) dut_rev (
        .clock            (clock),
        .reset_n          (reset_n),
        .io_wr            (rv_wr),
        .io_wr_ready      (rv_wr_ready),
        .io_len           (rv_len),
        .io_din           (rv_din),
        .io_rd            (rv_rd),
        .io_dout          (rv_dout),
        .io_isEmpty       (rv_empty),
        .io_isAlmostEmpty (rv_almost),
        .io_count         (rv_count),
        .io_pending       (rv_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW*DP-1:0] seq_din(input logic [DW-1:0] base);
        logic [DW*DP-1:0] d;
        for (int i = 0; i < DP; i++) d[i*DW +: DW] = base + DW'(i);
        return d;
    endfunction

    function automatic logic [DW*DP-1:0] fill_din(input logic [DW-1:0] v);
        logic [DW*DP-1:0] d;
        for (int i = 0; i < DP; i++) d[i*DW +: DW] = v;
        return d;
    endfunction

    // One clock on the forward instance. A pop compares the current head with
    // the scoreboard; an accepted write queues its elements in order.
    task automatic cyc(input bit do_rd, input bit do_wr, input int l,
                       input logic [DW*DP-1:0] d, input bit accept);
        int n;
        if (do_rd && q.size() > 0) check("dout", {24'd0, dout}, {24'd0, q.pop_front()});
        rd  = do_rd;
        wr  = do_wr;
        len = LW'(l);
        din = d;
        if (do_wr && accept) begin
            n = (l > DP) ? DP : l;
            for (int i = 0; i < n; i++) q.push_back(d[i*DW +: DW]);
        end
        tick();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("not_empty", {31'd0, empty}, 32'd0);
            if (q.size() == 1) check("almost_empty", {31'd0, almost}, 32'd1);
            cyc(1'b1, 1'b0, 0, '0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_dout",     {24'd0, dout},     32'd0);
        check("rst_empty",    {31'd0, empty},    32'd1);
        check("rst_almost",   {31'd0, almost},   32'd0);
        check("rst_count",    {27'd0, count},    32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_pending",  {31'd0, pending},  32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        wr = 1'b0; rd = 1'b0; len = '0; din = '0;
        rv_wr = 1'b0; rv_rd = 1'b0; rv_len = '0; rv_din = '0;
        tick();
        check_reset_outputs();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a drain with a word pending.
        cyc(1'b0, 1'b1, 16, seq_din(8'h40), 1'b1);
        cyc(1'b0, 1'b1, 16, seq_din(8'h50), 1'b1);
        cyc(1'b1, 1'b0, 0, '0, 1'b0);
        check("pre_rst_pending", {31'd0, pending}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        tick();
        reset_n = 1'b1;
        tick();

        // Basic full-length drain in forward order.
        cyc(1'b0, 1'b1, 16, seq_din(8'h10), 1'b1);
        check("count16", {27'd0, count}, 32'd16);
        drain(16);
        check("end_empty", {31'd0, empty}, 32'd1);
        check("end_dout",  {24'd0, dout},  32'd0);
        cyc(1'b1, 1'b0, 0, '0, 1'b0);
        check("pop_empty_dout",  {24'd0, dout},  32'd0);
        check("pop_empty_count", {27'd0, count}, 32'd0);

        // Back-to-back words with a blocked third write.
        cyc(1'b0, 1'b1, 3, seq_din(8'h01), 1'b1);
        check("a_count", {27'd0, count}, 32'd3);
        cyc(1'b1, 1'b1, 2, seq_din(8'h07), 1'b1);
        check("b_pending",  {31'd0, pending},  32'd1);
        check("b_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("b_count",    {27'd0, count},    32'd2);
        cyc(1'b0, 1'b1, 2, fill_din(8'hEE), 1'b0);
        check("blk_count",   {27'd0, count},   32'd2);
        check("blk_pending", {31'd0, pending}, 32'd1);
        drain(2);
        check("promo_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("promo_pending",  {31'd0, pending},  32'd0);
        check("promo_count",    {27'd0, count},    32'd2);
        drain(2);
        check("b2b_empty", {31'd0, empty}, 32'd1);
        check("b2b_dout",  {24'd0, dout},  32'd0);

        // Boundary lengths.
        cyc(1'b0, 1'b1, 0, seq_din(8'h20), 1'b1);
        check("len0_count", {27'd0, count}, 32'd0);
        check("len0_empty", {31'd0, empty}, 32'd1);
        check("len0_ready", {31'd0, wr_ready}, 32'd1);
        cyc(1'b0, 1'b1, 20, seq_din(8'h30), 1'b1);
        check("len20_count", {27'd0, count}, 32'd16);
        drain(16);
        check("len20_empty", {31'd0, empty}, 32'd1);

        // Last pop coincident with a write and nothing pending.
        cyc(1'b0, 1'b1, 1, fill_din(8'h55), 1'b1);
        check("co_count1", {27'd0, count}, 32'd1);
        cyc(1'b1, 1'b1, 2, seq_din(8'h66), 1'b1);
        check("co_dout",  {24'd0, dout},  32'd102);
        check("co_count", {27'd0, count}, 32'd2);
        check("co_empty", {31'd0, empty}, 32'd0);
        drain(2);
        check("co_end_empty", {31'd0, empty}, 32'd1);
        check("q_drained", q.size(), 32'd0);

        // Reverse order with a short length.
        rv_wr  = 1'b1;
        rv_len = LW'(4);
        rv_din = seq_din(8'hA0);
        for (int i = 3; i >= 0; i--) qr.push_back(8'hA0 + 8'(i));
        tick();
        rv_wr = 1'b0;
        check("rv_count", {27'd0, rv_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("rv_dout", {24'd0, rv_dout}, {24'd0, qr.pop_front()});
            rv_rd = 1'b1;
            tick();
            rv_rd = 1'b0;
        end
        check("rv_empty",    {31'd0, rv_empty}, 32'd1);
        check("rv_end_dout", {24'd0, rv_dout},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
